i2c_eeprom_slave: RTL and testbench

I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

---
 rtl/i2c_eeprom_slave.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_slave.sv
// I2C serial EEPROM slave (24Cxx style): device select, byte/page write with
// page roll-over, current/random/sequential read, write cycle with ACK polling.
module i2c_eeprom_slave #(
  parameter int ADDR_BYTES   = 1,
  parameter int BLOCK_BITS   = 3,
  parameter int PAGE_SIZE    = 16,
  parameter int WRITE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [2:0] a_pins,
  input  logic       wp,
  output logic       busy
);
  localparam int LOW_W  = 8 * ADDR_BYTES;
  localparam int MEM_AW = LOW_W + BLOCK_BITS;
  localparam int PG_W   = $clog2(PAGE_SIZE);
  localparam int WC_W   = $clog2(WRITE_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, DEVSEL, DEVSEL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WCYCLE
  } state_t;

  state_t            state;
  logic [1:0]        scl_sync, sda_sync;
  logic              scl_q, sda_q;
  logic [3:0]        bitcnt;
  logic [7:0]        sr;
  logic [MEM_AW-1:0] ptr;
  logic [WC_W-1:0]   wcnt;
  logic [1:0]        abyte;
  logic              rw, wrote, mack;
  logic [7:0]        mem [0:(1<<MEM_AW)-1];

  logic scl, sda, scl_rise, scl_fall, start, stop, mem_we;

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;
  assign mem_we   = (state == WDATA) && scl_fall && (bitcnt == 4'd8) && !wp && !rst;

  function automatic logic dev_match(input logic [7:0] b, input logic [2:0] pins);
    logic m;
    m = (b[7:4] == 4'b1010);
    for (int i = BLOCK_BITS; i < 3; i++)
      if (b[i+1] != pins[i]) m = 1'b0;
    return m;
  endfunction

  function automatic logic [MEM_AW-1:0] set_block(input logic [MEM_AW-1:0] p, input logic [7:0] b);
    logic [MEM_AW-1:0] r;
    r = p;
    for (int i = 0; i < BLOCK_BITS; i++) r[LOW_W+i] = b[i+1];
    return r;
  endfunction

  // Address bytes arrive MSB byte first, so each one shifts the low field up.
  function automatic logic [MEM_AW-1:0] shift_addr(input logic [MEM_AW-1:0] p, input logic [7:0] b);
    logic [LOW_W+7:0]  t;
    logic [MEM_AW-1:0] r;
    t = {p[LOW_W-1:0], b};
    r = p;
    r[LOW_W-1:0] = t[LOW_W-1:0];
    return r;
  endfunction

  function automatic logic [MEM_AW-1:0] page_inc(input logic [MEM_AW-1:0] p);
    logic [MEM_AW-1:0] r;
    r = p;
    r[PG_W-1:0] = p[PG_W-1:0] + 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= sr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      bitcnt   <= '0;
      wcnt     <= '0;
      abyte    <= '0;
      rw       <= 1'b0;
      wrote    <= 1'b0;
      mack     <= 1'b0;
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl;
      sda_q    <= sda;
      // The write cycle is deaf to the bus, so polling control bytes see NACK.
      if (state == WCYCLE) begin
        if (wcnt == WC_W'(WRITE_CYCLES - 1)) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end else if (start) begin
        state  <= DEVSEL;
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else if (stop) begin
        sda_oe <= 1'b0;
        bitcnt <= '0;
        if (wrote) begin
          state <= WCYCLE;
          busy  <= 1'b1;
          wcnt  <= '0;
          wrote <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          DEVSEL, ADDR, WDATA: begin
            if (scl_rise && bitcnt != 4'd8) begin
              sr     <= {sr[6:0], sda};
              bitcnt <= bitcnt + 1'b1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              if (state == DEVSEL) begin
                if (dev_match(sr, a_pins)) begin
                  sda_oe <= 1'b1;
                  rw     <= sr[0];
                  state  <= DEVSEL_ACK;
                  if (!sr[0]) ptr <= set_block(ptr, sr);
                end else begin
                  state <= IDLE;
                end
              end else if (state == ADDR) begin
                sda_oe <= 1'b1;
                ptr    <= shift_addr(ptr, sr);
                abyte  <= abyte + 1'b1;
                state  <= ADDR_ACK;
              end else begin
                if (!wp) begin
                  sda_oe <= 1'b1;
                  ptr    <= page_inc(ptr);
                  wrote  <= 1'b1;
                end
                state <= WDATA_ACK;
              end
            end
          end
          DEVSEL_ACK: if (scl_fall) begin
            if (rw) begin
              sr     <= mem[ptr];
              sda_oe <= ~mem[ptr][7];
              bitcnt <= '0;
              state  <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              abyte  <= '0;
              state  <= ADDR;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= (abyte == 2'(ADDR_BYTES)) ? WDATA : ADDR;
          end
          WDATA_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WDATA;
          end
          RDATA: begin
            if (scl_rise && bitcnt != 4'd8) begin
              bitcnt <= bitcnt + 1'b1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 1'b1;
                bitcnt <= '0;
                state  <= RD_MACK;
              end else begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              mack <= ~sda;
            end else if (scl_fall) begin
              if (mack) begin
                sr     <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
                state  <= RDATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bus-master bench for i2c_eeprom_slave: directed transactions push expected
// ACK/data/busy values into a queue that a separate monitor compares.
module tb_i2c_eeprom_slave;
  localparam int QT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wp = 1'b0;
  logic [2:0] a_pins = 3'b000;
  logic       sda_bus;
  logic       sda_oe, busy;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk    (clk),
    .rst    (rst),
    .scl_in (scl_m),
    .sda_in (sda_bus),
    .sda_oe (sda_oe),
    .a_pins (a_pins),
    .wp     (wp),
    .busy   (busy)
  );

  string exp_name[$];
  int    exp_val[$];
  int    act_val[$];
  int    checks = 0;
  int    passed = 0;

  // Length of the most recent busy pulse in clk cycles.
  logic busy_q = 1'b0;
  int   busy_run = 0;
  always @(posedge clk) begin
    busy_q <= busy;
    if (busy) busy_run <= busy_q ? busy_run + 1 : 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      while (act_val.size() > 0) begin
        int    a, e;
        string n;
        a = act_val.pop_front();
        checks++;
        if (exp_val.size() == 0) begin
          $display("FAIL unexpected_output: got %0h required nothing", a);
        end else begin
          e = exp_val.pop_front();
          n = exp_name.pop_front();
          if (a == e) passed++;
          else $display("FAIL %s: got %0h required %0h", n, a, e);
        end
      end
    end
  end

  task automatic expect_val(input string n, input int v);
    exp_name.push_back(n);
    exp_val.push_back(v);
  endtask

  task automatic observe(input int v);
    act_val.push_back(v);
  endtask

  task automatic check_now(input string n, input int e, input int v);
    expect_val(n, e);
    observe(v);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; #QT;
    scl_m = 1'b1; #QT;
    sda_m = 1'b0; #QT;
    scl_m = 1'b0; #QT;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; #QT;
    scl_m = 1'b1; #QT;
    sda_m = 1'b1; #QT;
  endtask

  task automatic send_byte(input string n, input logic [7:0] b, input int exp_ack);
    expect_val(n, exp_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #QT;
      scl_m = 1'b1; #(2*QT);
      scl_m = 1'b0; #QT;
    end
    sda_m = 1'b1; #QT;
    scl_m = 1'b1; #QT;
    observe(sda_bus ? 0 : 1);
    #QT;
    scl_m = 1'b0; #QT;
  endtask

  task automatic read_byte(input string n, input int exp_data, input bit ack);
    logic [7:0] v;
    v = '0;
    expect_val(n, exp_data);
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #QT;
      scl_m = 1'b1; #QT;
      v = {v[6:0], sda_bus};
      #QT;
      scl_m = 1'b0; #QT;
    end
    observe(int'(v));
    sda_m = ack ? 1'b0 : 1'b1; #QT;
    scl_m = 1'b1; #(2*QT);
    scl_m = 1'b0; #QT;
    sda_m = 1'b1;
  endtask

  task automatic wait_busy_low;
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check_now("busy_expired", 0, int'(busy));
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_now("reset_sda_oe", 0, int'(sda_oe));
    check_now("reset_busy", 0, int'(busy));
    rst = 1'b0;
    #(4*QT);

    // Byte write to 0x23C, then ACK polling during and after the write cycle
    bus_start;
    send_byte("bw_ctrl_ack", 8'hA4, 1);
    send_byte("bw_addr_ack", 8'h3C, 1);
    send_byte("bw_data_ack", 8'h5A, 1);
    bus_stop;
    check_now("busy_after_stop", 1, int'(busy));
    bus_start;
    send_byte("poll_busy_nack", 8'hA0, 0);
    bus_stop;
    wait_busy_low;
    check_now("busy_length", 1000, busy_run);
    bus_start;
    send_byte("poll_ready_ack", 8'hA0, 1);
    bus_stop;
    #(4*QT);
    check_now("no_write_no_busy", 0, int'(busy));
    bus_start;
    send_byte("rb_ctrl_ack", 8'hA4, 1);
    send_byte("rb_addr_ack", 8'h3C, 1);
    bus_start;
    send_byte("rb_rctrl_ack", 8'hA5, 1);
    read_byte("rb_data_23c", 8'h5A, 1'b0);
    bus_stop;

    // Page write of 18 bytes from 0x00E wraps inside the 16-byte page
    bus_start;
    send_byte("pg_ctrl_ack", 8'hA0, 1);
    send_byte("pg_addr_ack", 8'h0E, 1);
    for (int i = 0; i < 18; i++) send_byte("pg_data_ack", 8'(i), 1);
    bus_stop;
    wait_busy_low;
    bus_start;
    send_byte("pr_ctrl_ack", 8'hA0, 1);
    send_byte("pr_addr_ack", 8'h00, 1);
    bus_start;
    send_byte("pr_rctrl_ack", 8'hA1, 1);
    for (int i = 0; i < 16; i++) read_byte("pr_data", i + 2, i < 15);
    bus_stop;

    // Random read across the top of memory wraps to 0x000
    bus_start;
    send_byte("top_ctrl_ack", 8'hAE, 1);
    send_byte("top_addr_ack", 8'hFF, 1);
    send_byte("top_data_ack", 8'hC3, 1);
    bus_stop;
    wait_busy_low;
    bus_start;
    send_byte("rr_ctrl_ack", 8'hAE, 1);
    send_byte("rr_addr_ack", 8'hFF, 1);
    bus_start;
    send_byte("rr_rctrl_ack", 8'hAF, 1);
    read_byte("rr_data_7ff", 8'hC3, 1'b1);
    read_byte("rr_data_000", 8'h02, 1'b0);
    bus_stop;

    // Write protect: address ACKed, data NACKed, nothing committed
    wp = 1'b1;
    bus_start;
    send_byte("wp_ctrl_ack", 8'hA0, 1);
    send_byte("wp_addr_ack", 8'h05, 1);
    send_byte("wp_data_nack", 8'h77, 0);
    bus_stop;
    #(4*QT);
    check_now("wp_no_busy", 0, int'(busy));
    wp = 1'b0;
    bus_start;
    send_byte("wpr_ctrl_ack", 8'hA0, 1);
    send_byte("wpr_addr_ack", 8'h05, 1);
    bus_start;
    send_byte("wpr_rctrl_ack", 8'hA1, 1);
    read_byte("wpr_data_005", 8'h07, 1'b0);
    bus_stop;

    // Reset in the middle of a read releases SDA and clears the pointer
    bus_start;
    send_byte("rst_ctrl_ack", 8'hA0, 1);
    send_byte("rst_addr_ack", 8'h00, 1);
    bus_start;
    send_byte("rst_rctrl_ack", 8'hA1, 1);
    read_byte("rst_data_000", 8'h02, 1'b1);
    check_now("rdata_driving", 1, int'(sda_oe));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_now("rst_release_sda", 0, int'(sda_oe));
    @(negedge clk);
    rst = 1'b0;
    bus_stop;
    bus_start;
    send_byte("post_rst_ctrl_ack", 8'hA1, 1);
    read_byte("post_rst_data", 8'h02, 1'b0);
    bus_stop;

    repeat (20) @(negedge clk);
    while (exp_val.size() > 0) begin
      checks++;
      $display("FAIL %s: got no output required %0h", exp_name.pop_front(), exp_val.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
